ram64_write_queue: RTL and testbench

RAM64_WRITE_QUEUE -- requirements
Module: ram64_write_queue

---
 rtl/ram64_wq_pkg.sv | 13 +
 rtl/ram64_wq_fifo.sv | 75 +++++++
 rtl/ram64_write_queue.sv | 116 +++++++++++
 tb/tb_ram64_write_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram64_wq_pkg.sv
// Shared widths, queue depth and drain-FSM encoding for the RAM64 write queue.
package ram64_wq_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wq_state_t;
endpackage

// File: rtl/ram64_wq_fifo.sv
// Circular {addr,data} store with head/tail pointers and occupancy count; push/pop take effect on the edge.
// With RAM64_WQ_COALESCE_EN, merge rewrites the data of the newest entry instead of allocating.
module ram64_wq_fifo
  import ram64_wq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
`ifdef RAM64_WQ_COALESCE_EN
  input  logic                     merge,
  output logic [ADDR_W-1:0]        tail_addr,
`endif
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [ADDR_W-1:0]        next_addr,
  output logic [DATA_W-1:0]        next_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_ptr, tail_ptr, head_nxt;

  assign head_nxt  = head_ptr + PTR_W'(1);
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[head_ptr];
  assign head_data = data_mem[head_ptr];
  assign next_addr = addr_mem[head_nxt];
  assign next_data = data_mem[head_nxt];

`ifdef RAM64_WQ_COALESCE_EN
  logic [PTR_W-1:0] tail_last;
  assign tail_last = tail_ptr - PTR_W'(1);
  assign tail_addr = addr_mem[tail_last];
`endif

  // Storage needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_ptr] <= push_addr;
      data_mem[tail_ptr] <= push_data;
    end
`ifdef RAM64_WQ_COALESCE_EN
    if (merge) data_mem[tail_last] <= push_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ram64_write_queue.sv
// Queues {addr,data} writes and drains each to RAM64 as SETUP/STROBE/HOLD (one write per 3 cycles).
// req_ready comes from registered occupancy only; RAM64_WQ_COALESCE_EN merges same-address tail writes.
module ram64_write_queue
  import ram64_wq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W-1:0]      mem_in,
  output logic                   mem_load,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wq_state_t         state;
  logic              full, empty, accept, push, pop;
  logic [ADDR_W-1:0] head_addr, next_addr, load_addr;
  logic [DATA_W-1:0] head_data, next_data, load_data;

  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign pop       = (state == HOLD);
  assign busy      = (count != '0) || (state != IDLE);
  assign load_addr = (state == HOLD) ? next_addr : head_addr;

`ifdef RAM64_WQ_COALESCE_EN
  logic              merge, tail_in_drain, fwd;
  logic [ADDR_W-1:0] tail_addr;
  // With one entry outside IDLE, the tail is the word already on the RAM pins.
  assign tail_in_drain = (count == CNT_W'(1)) && (state != IDLE);
  assign merge = accept && !empty && !tail_in_drain && (req_addr == tail_addr);
  assign push  = accept && !merge;
  // A merge into the entry being latched this edge must reach mem_in directly.
  assign fwd = merge && (((state == IDLE) && (count == CNT_W'(1))) ||
                         ((state == HOLD) && (count == CNT_W'(2))));
  assign load_data = fwd ? req_data : ((state == HOLD) ? next_data : head_data);
`else
  assign push      = accept;
  assign load_data = (state == HOLD) ? next_data : head_data;
`endif

  ram64_wq_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (req_addr),
    .push_data (req_data),
`ifdef RAM64_WQ_COALESCE_EN
    .merge     (merge),
    .tail_addr (tail_addr),
`endif
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data),
    .next_addr (next_addr),
    .next_data (next_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_address <= '0;
      mem_in      <= '0;
      mem_load    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_load <= 1'b0;
          if (!empty) begin
            state       <= SETUP;
            mem_address <= load_addr;
            mem_in      <= load_data;
          end
        end
        SETUP: begin
          state    <= STROBE;
          mem_load <= 1'b1;
        end
        STROBE: begin
          state    <= HOLD;
          mem_load <= 1'b0;
        end
        HOLD: begin
          mem_load <= 1'b0;
          if (count > CNT_W'(1)) begin
            state       <= SETUP;
            mem_address <= load_addr;
            mem_in      <= load_data;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          mem_load <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram64_write_queue.sv
// Bench for ram64_write_queue: RAM64 model plus write scoreboard, single-write vector table, multi-cycle corner sequences.
module tb_ram64_write_queue;
`ifdef RAM64_WQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    logic [3:0]  exp_ld;   // mem_load on the 1st..4th cycle after the accept edge
    logic [2:0]  exp_cnt;  // occupancy right after the accept
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic [5:0]  mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [2:0]  count;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_wr    = 0;
  int          n_wr9   = 0;
  logic [15:0] ram [64];
  wr_t         exp_q [$];
  int          wr_cyc [$];

  ram64_write_queue dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .count       (count),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM64 model: mem_load is high for exactly one cycle per write.
  always @(negedge clk) begin
    if (mem_load) begin
      ram[mem_address] = mem_in;
      n_wr++;
      wr_cyc.push_back(cyc);
      if (mem_address == 6'd9) n_wr9++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: write addr=%0d data=0x%0h with nothing expected", mem_address, mem_in);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 32'(mem_address), 32'(e.addr));
        chk("sb_data", 32'(mem_in), 32'(e.data));
      end
    end
  end

  // Holds the request until accepted; returns at the negedge after the accept edge.
  task automatic push_req(input logic [5:0] a, input logic [15:0] d, input bit merge, output int acc_cyc);
    bit done;
    wr_t e;
    done    = 1'b0;
    acc_cyc = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int k = 0; k < 40 && !done; k++) begin
      if (req_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
        if (merge && exp_q.size() > 0) begin
          exp_q[exp_q.size()-1].data = d;
        end else begin
          e.addr = a;
          e.data = d;
          exp_q.push_back(e);
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: addr=%0d never accepted, req_ready=%0b expected 1", a, req_ready);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(busy), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    int   ac [5];
    int   w0, nw, dummy;

    vecs[0] = '{addr: 6'd5,  data: 16'hBEEF, exp_ld: 4'b0100, exp_cnt: 3'd1};
    vecs[1] = '{addr: 6'd0,  data: 16'h0000, exp_ld: 4'b0100, exp_cnt: 3'd1};
    vecs[2] = '{addr: 6'd63, data: 16'hFFFF, exp_ld: 4'b0100, exp_cnt: 3'd1};
    vecs[3] = '{addr: 6'd42, data: 16'hA5A5, exp_ld: 4'b0100, exp_cnt: 3'd1};

    for (int i = 0; i < 64; i++) ram[i] = 16'h0000;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(mem_load), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_in", 32'(mem_in), 32'd0);
    @(negedge clk);

    // Single writes into an empty idle queue
    for (int i = 0; i < 4; i++) begin
      wr_t e;
      chk("vec_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = vecs[i].addr;
      req_data  = vecs[i].data;
      e.addr = vecs[i].addr;
      e.data = vecs[i].data;
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      chk("vec_count", 32'(count), 32'(vecs[i].exp_cnt));
      for (int k = 0; k < 4; k++) begin
        chk("vec_load", 32'(mem_load), 32'(vecs[i].exp_ld[k]));
        if (k == 2) begin
          chk("vec_mem_addr", 32'(mem_address), 32'(vecs[i].addr));
          chk("vec_mem_in", 32'(mem_in), 32'(vecs[i].data));
        end
        @(negedge clk);
      end
      chk("vec_count_end", 32'(count), 32'd0);
      chk("vec_busy_end", 32'(busy), 32'd0);
      chk("vec_ram", 32'(ram[vecs[i].addr]), 32'(vecs[i].data));
    end

    // Five back-to-back pushes into a 4-deep queue, push blocked on the HOLD-exit edge
    w0 = wr_cyc.size();
    for (int i = 0; i < 5; i++) begin
      push_req(6'(i), 16'h1000 + 16'(i), 1'b0, ac[i]);
      if (i == 3) begin
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
      end
    end
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(ac[i] - ac[i-1]), 32'd1);
    chk("fifth_gap", 32'(ac[4] - ac[3]), 32'd2);
    chk("refill_count", 32'(count), 32'd4);
    wait_idle("b2b_idle");
    chk("b2b_nwr", 32'(wr_cyc.size() - w0), 32'd5);
    if (wr_cyc.size() - w0 == 5)
      for (int i = 1; i < 5; i++) chk("wr_spacing", 32'(wr_cyc[w0+i] - wr_cyc[w0+i-1]), 32'd3);
    for (int i = 0; i < 5; i++) chk("b2b_ram", 32'(ram[i]), 32'(16'h1000 + 16'(i)));

    // Reset during STROBE of a 3-entry queue
    push_req(6'd10, 16'h0A0A, 1'b0, dummy);
    push_req(6'd11, 16'h0B0B, 1'b0, dummy);
    push_req(6'd12, 16'h0C0C, 1'b0, dummy);
    req_valid = 1'b0;
    chk("mid_strobe_load", 32'(mem_load), 32'd1);
    chk("mid_strobe_count", 32'(count), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nw = n_wr;
    exp_q.delete();
    chk("mid_rst_load", 32'(mem_load), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (20) @(negedge clk);
    chk("mid_rst_no_wr", 32'(n_wr), 32'(nw));
    chk("mid_rst_ram10", 32'(ram[10]), 32'h0A0A);
    chk("mid_rst_ram11", 32'(ram[11]), 32'h0000);
    chk("mid_rst_ram12", 32'(ram[12]), 32'h0000);

    // Same-address write behind an active drain
    n_wr9 = 0;
    push_req(6'd20, 16'h2020, 1'b0, dummy);
    push_req(6'd9,  16'h0001, 1'b0, dummy);
    push_req(6'd9,  16'h0002, COAL, dummy);
    req_valid = 1'b0;
    chk("coal_count", 32'(count), COAL ? 32'd2 : 32'd3);
    wait_idle("coal_idle");
    chk("coal_ram9", 32'(ram[9]), 32'h0002);
    chk("coal_nwr9", 32'(n_wr9), COAL ? 32'd1 : 32'd2);
    chk("coal_ram20", 32'(ram[20]), 32'h2020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
